// File: rtl/pe_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// controller states, Booth group codes and partial-product selectors.
package pe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Radix-4 Booth group codes {m[2g+1], m[2g], m[2g-1]}
   localparam logic [2:0] BG_000 = 3'b000;
   localparam logic [2:0] BG_001 = 3'b001;
   localparam logic [2:0] BG_010 = 3'b010;
   localparam logic [2:0] BG_011 = 3'b011;
   localparam logic [2:0] BG_100 = 3'b100;
   localparam logic [2:0] BG_101 = 3'b101;
   localparam logic [2:0] BG_110 = 3'b110;
   localparam logic [2:0] BG_111 = 3'b111;

   typedef enum logic [2:0] {
      PP_ZERO = 3'd0,
      PP_POS1 = 3'd1,
      PP_POS2 = 3'd2,
      PP_NEG1 = 3'd3,
      PP_NEG2 = 3'd4
   } pp_sel_t;

   localparam int unsigned DEFAULT_N_BITS = 32;
   localparam int unsigned GROUPS         = DEFAULT_N_BITS / 2;
   localparam int unsigned GROUP_INDEX_W  = 5;
   localparam int unsigned MAX_N_BITS     = 2 * (2 ** GROUP_INDEX_W);

   function automatic int unsigned groups_of(input int unsigned n_bits);
      return n_bits / 2;
   endfunction

   function automatic pp_sel_t decode_group(input logic [2:0] grp);
      pp_sel_t sel;
      case (grp)
         BG_001, BG_010: sel = PP_POS1;
         BG_011:         sel = PP_POS2;
         BG_100:         sel = PP_NEG2;
         BG_101, BG_110: sel = PP_NEG1;
         default:        sel = PP_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_seq_multiplier_booth_encoder.sv
// Radix-4 Booth partial-product generator: selects 0/+-M/+-2M from one
// Booth group, sign-extends to the accumulator width and aligns by 2*g.
module BoothEncoder
   import pe_pkg::*;
#(
   parameter int unsigned N_BITS = 32
) (
   input  logic [GROUP_INDEX_W-1:0] group_index,
   input  logic [2:0]               booth_group,
   input  logic [N_BITS-1:0]        multiplicand,
   output logic [2*N_BITS:0]        partial_product
);

   localparam int unsigned ACC_W = 2 * N_BITS + 1;

   logic [ACC_W-1:0]       m_ext;
   logic [ACC_W-1:0]       pp_unshifted;
   logic [GROUP_INDEX_W:0] shift_amt;
   pp_sel_t                sel;

   always_comb begin
      m_ext     = {{(ACC_W - N_BITS){multiplicand[N_BITS-1]}}, multiplicand};
      sel       = decode_group(booth_group);
      shift_amt = {group_index, 1'b0};
      case (sel)
         PP_POS1: pp_unshifted = m_ext;
         PP_POS2: pp_unshifted = m_ext << 1;
         PP_NEG1: pp_unshifted = -m_ext;
         PP_NEG2: pp_unshifted = -(m_ext << 1);
         default: pp_unshifted = '0;
      endcase
      partial_product = pp_unshifted << shift_amt;
   end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle,
// fixed N_BITS/2-cycle latency, valid/ready handshakes on both sides.
module booth_seq_multiplier
   import pe_pkg::*;
#(
   parameter int unsigned N_BITS = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_BITS-1:0]     multiplicand,
   input  logic [N_BITS-1:0]     multiplier,
   input  logic                  clear,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*N_BITS-1:0]   product
);

   localparam int unsigned N_GROUPS = groups_of(N_BITS);
   localparam int unsigned ACC_W    = 2 * N_BITS + 1;
   localparam logic [GROUP_INDEX_W-1:0] LAST_G = GROUP_INDEX_W'(N_GROUPS - 1);

   generate
      if (N_BITS == 0 || N_BITS > MAX_N_BITS || (N_BITS % 2) != 0) begin : g_bad_width
         $error("booth_seq_multiplier: N_BITS must be even and in 2..64");
      end
   endgenerate

   state_t                   state_q, state_d;
   logic [N_BITS-1:0]        mcand_q;
   logic [N_BITS-1:0]        mplier_q;
   logic [ACC_W-1:0]         acc_q;
   logic [ACC_W-1:0]         pp;
   logic [GROUP_INDEX_W-1:0] g_q;
   logic [N_BITS:0]          mplier_pad;
   logic [2:0]               booth_group;
   logic                     accept;
   logic                     last_group;

   always_comb begin
      // m[-1] = 0 is supplied by the appended zero LSB
      mplier_pad  = {mplier_q, 1'b0};
      booth_group = mplier_pad[{g_q, 1'b0} +: 3];
      accept      = (state_q == ST_IDLE) && in_valid && !clear;
      last_group  = (g_q == LAST_G);
   end

   BoothEncoder #(
      .N_BITS (N_BITS)
   ) u_booth_encoder (
      .group_index     (g_q),
      .booth_group     (booth_group),
      .multiplicand    (mcand_q),
      .partial_product (pp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_BUSY;
            ST_BUSY: if (last_group) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      busy      = (state_q == ST_BUSY);
      out_valid = (state_q == ST_DONE);
      product   = out_valid ? acc_q[2*N_BITS-1:0] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         g_q      <= '0;
      end else if (clear) begin
         acc_q <= '0;
         g_q   <= '0;
      end else if (accept) begin
         mcand_q  <= multiplicand;
         mplier_q <= multiplier;
         acc_q    <= '0;
         g_q      <= '0;
      end else if (state_q == ST_BUSY) begin
         acc_q <= acc_q + pp;
         g_q   <= g_q + GROUP_INDEX_W'(1);
      end
   end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier: vector table plus hand-written
// backpressure, abort, async reset and back-to-back sequences.
module tb_booth_seq_multiplier;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        clear;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;

   int total;
   int bad;

   booth_seq_multiplier #(
      .N_BITS (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .clear        (clear),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one pair, scrambles the inputs after the accept edge and
   // counts edges until out_valid rises (bounded).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      multiplicand = ~a;
      multiplier   = ~b;
      chk("busy_after_accept", 64'(busy), 64'd1);
      lat = 0;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      p = product;
   endtask

   task automatic release_op();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("in_ready_after_done", 64'(in_ready), 64'd1);
      chk("product_zero_idle", product, 64'd0);
   endtask

   task automatic watch_no_valid(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk(name, 64'(seen), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] p;
      int          lat;
      logic [31:0] bb_a[3];
      logic [31:0] bb_b[3];
      logic [63:0] bb_e[3];

      total = 0;
      bad   = 0;

      vecs[0] = '{"3x5",         32'd3,          32'd5,          64'd15};
      vecs[1] = '{"m7x6",        -32'sd7,        32'd6,          -64'sd42};
      vecs[2] = '{"m1xm1",       32'hFFFFFFFF,   32'hFFFFFFFF,   64'd1};
      vecs[3] = '{"min_x_min",   32'h80000000,   32'h80000000,   64'h4000000000000000};
      vecs[4] = '{"min_x_m1",    32'h80000000,   32'hFFFFFFFF,   64'h0000000080000000};
      vecs[5] = '{"max_x_max",   32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF00000001};
      vecs[6] = '{"max_x_min",   32'h7FFFFFFF,   32'h80000000,   64'hC000000080000000};
      vecs[7] = '{"1234xm5678",  32'd1234,       -32'sd5678,     -64'sd7006652};

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      clear        = 1'b0;
      out_ready    = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      #1;
      chk("reset_in_ready",  64'(in_ready),  64'd1);
      chk("reset_busy",      64'(busy),      64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_product",   product,        64'd0);
      #11;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, p, lat);
         chk({"prod_", vecs[i].name}, p, vecs[i].exp);
         chk({"lat_", vecs[i].name}, 64'(lat), 64'd16);
         release_op();
      end

      // Backpressure: product held, inputs ignored while DONE
      do_op(32'd11, 32'd13, p, lat);
      chk("bp_prod", p, 64'd143);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid     = (i % 2) == 0;
         multiplicand = 32'd99;
         multiplier   = 32'd99;
         chk("bp_hold_prod",     product,         64'd143);
         chk("bp_hold_in_ready", 64'(in_ready),   64'd0);
         chk("bp_hold_valid",    64'(out_valid),  64'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_still_prod", product, 64'd143);
      release_op();
      chk("bp_valid_low", 64'(out_valid), 64'd0);

      // Abort with clear during the 8th BUSY cycle
      @(negedge clk);
      multiplicand = 32'd9;
      multiplier   = 32'd9;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'd1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_busy",     64'(busy),     64'd0);
      watch_no_valid("abort_no_valid", 30);
      do_op(32'd2, 32'd2, p, lat);
      chk("abort_next_prod", p, 64'd4);
      chk("abort_next_lat", 64'(lat), 64'd16);
      release_op();

      // Asynchronous reset mid-BUSY
      @(negedge clk);
      multiplicand = 32'd50;
      multiplier   = 32'd50;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready",  64'(in_ready),  64'd1);
      chk("arst_busy",      64'(busy),      64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_product",   product,        64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_valid("arst_no_valid", 25);
      do_op(32'd100, -32'sd3, p, lat);
      chk("arst_next_prod", p, -64'sd300);
      release_op();

      // Back-to-back with in_valid held and out_ready tied high
      bb_a[0] = 32'd1000;     bb_b[0] = 32'd1000;     bb_e[0] = 64'd1000000;
      bb_a[1] = -32'sd5;      bb_b[1] = 32'd7;        bb_e[1] = -64'sd35;
      bb_a[2] = 32'h7FFFFFFF; bb_b[2] = 32'hFFFFFFFF; bb_e[2] = 64'hFFFFFFFF80000001;
      @(negedge clk);
      out_ready    = 1'b1;
      in_valid     = 1'b1;
      multiplicand = bb_a[0];
      multiplier   = bb_b[0];
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (k < 2) begin
            multiplicand = bb_a[k+1];
            multiplier   = bb_b[k+1];
         end else begin
            in_valid = 1'b0;
         end
         chk("b2b_busy", 64'(busy), 64'd1);
         lat = 0;
         while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
         end
         chk("b2b_prod", product, bb_e[k]);
         chk("b2b_lat", 64'(lat), 64'd16);
         @(posedge clk);
         #1;
         chk("b2b_idle", 64'(in_ready), 64'd1);
      end
      out_ready = 1'b0;
      watch_no_valid("b2b_no_extra", 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/booth_seq_multiplier.md
BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 The block SHALL have parameter N_BITS, default 32, meaning operand width; it SHALL be even and at most 64.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 multiplicand  input  N_BITS  signed two's-complement operand.
REQ-007 multiplier  input  N_BITS  signed two's-complement operand; this operand is Booth-recoded.
REQ-008 clear  input  1  synchronous abort; discards any operation in flight.
REQ-009 busy  output  1  high while partial products are being accumulated.
REQ-010 out_valid  output  1  product valid.
REQ-011 out_ready  input  1  consumer accepts the product.
REQ-012 product  output  2*N_BITS  signed product, multiplicand times multiplier.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and DONE; in_ready = (state==IDLE), busy = (state==BUSY), out_valid = (state==DONE).
REQ-014 In IDLE, an edge with in_valid&in_ready&!clear SHALL latch both operands, zero the accumulator, set group counter g=0 and enter BUSY.
REQ-015 Each BUSY cycle SHALL form booth group {m[2g+1], m[2g], m[2g-1]} from the latched multiplier, with m[-1]=0.
REQ-016 Each BUSY cycle SHALL add the radix-4 partial product to the accumulator: 000/111 add 0; 001/010 add +M; 011 adds +2M; 100 adds -2M; 101/110 add -M. The partial product SHALL be sign-extended to 2*N_BITS+1 bits and shifted left by 2g.
REQ-017 The accumulator SHALL be 2*N_BITS+1 bits wide and wrap modulo 2^(2*N_BITS+1); product SHALL equal accumulator[2*N_BITS-1:0], which is exact for all signed operand pairs.
REQ-018 g SHALL increment each BUSY cycle. On the cycle with g==N_BITS/2-1, the last partial product SHALL be added and the state SHALL go to DONE.
REQ-019 Latency SHALL be fixed: if the accept edge is E0, BUSY spans edges E1..E(N_BITS/2), and out_valid is high after edge E(N_BITS/2), which is 16 cycles for N_BITS=32. There SHALL be no early termination.
REQ-020 In DONE, product SHALL be held stable until the edge with out_ready high; that edge SHALL return the state to IDLE. An accept SHALL not occur on that same edge, because in_ready is low in DONE.
REQ-021 in_valid while not in IDLE SHALL be ignored; the latched operands SHALL not change during BUSY or DONE.
REQ-022 clear high in any state SHALL force IDLE on the next edge and zero the accumulator, g and product.
REQ-023 clear SHALL win over in_valid and over out_ready on the same edge; no accept or handshake SHALL be reported on that edge.
REQ-024 product SHALL be 0 whenever out_valid is low.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, g=0, accumulator=0 and latched operands=0, regardless of clk.
REQ-026 Reset values SHALL be: in_ready=1, busy=0, out_valid=0, product=0.
REQ-027 Reset deassertion mid-operation SHALL resume from IDLE; the aborted operation SHALL produce no output.

Structure
REQ-028 State encodings (IDLE/BUSY/DONE) and the radix-4 group-code constants SHALL live in the shared pe_pkg package, alongside GROUPS = N_BITS/2.
REQ-029 The partial-product generation SHALL be one instance of the existing sub-module BoothEncoder, driven by g (zero-extended to 5 bits) and the current booth group. The accumulator and controller SHALL stay in this module.
REQ-030 The 5-bit group_index SHALL limit N_BITS to 64; a larger N_BITS SHALL be rejected at elaboration.

Verification
REQ-031 Accept 3 x 5 -> out_valid exactly 16 cycles after the accept edge, product=15.
REQ-032 Signed corners:
- -7 x 6 -> product=-42;
- -1 x -1 -> product=1;
- 0x80000000 x 0x80000000 -> product=0x4000000000000000;
- 0x80000000 x 0xFFFFFFFF -> product=0x0000000080000000.
REQ-033 Backpressure: hold out_ready low 5 cycles after out_valid -> product stable, in_ready=0, and in_valid pulses ignored. Then out_ready=1 for one edge -> IDLE, in_ready=1.
REQ-034 Abort: assert clear on the 8th BUSY cycle -> IDLE next edge, out_valid never rises. A new 2 x 2 then yields 4.
REQ-035 Reset: drop rst_n asynchronously mid-BUSY -> outputs at reset values before the next clk edge. A subsequent 100 x -3 yields -300.
REQ-036 Back-to-back: in_valid held high across 3 operand pairs, out_ready tied high -> 3 correct products, each 16 BUSY cycles apart plus one DONE and one IDLE cycle.
